// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RV32 pipeline slice: datapath width, the x0
// register index, 4-bit ALU operation encodings and the decoded control
// bundle carried from ID into EX.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32_pkg;

    localparam int          XLEN     = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // ALU operation encodings carried on id_alu_op / ex_alu_op.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_e;

    // Decoded control bundle, one bit per field.
    typedef struct packed {
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic jump;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detection between the instruction in EX
// (a load) and the instruction in ID (a consumer of the load result).
// Ports:
//   i_ex_valid, i_ex_mem_read, i_ex_rd  - instruction currently in EX
//   i_id_valid, i_id_rs1/2, i_id_use_rs1/2 - instruction currently in ID
//   i_flush                             - redirect from EX
//   o_hz                                - raw hazard term
//   o_load_use_stall                    - freeze PC and IF/ID (hazard, no flush)
// ---------------------------------------------------------------------------
module load_use_detect
    import rv32_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic       i_flush,
    output logic       o_hz,
    output logic       o_load_use_stall
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_match = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign o_hz = i_ex_valid && i_ex_mem_read && (i_ex_rd != REG_ZERO) &&
                  i_id_valid && (w_rs1_match || w_rs2_match);

    // A redirect kills the ID instruction anyway, so freezing it is pointless.
    // Downstream hold is deliberately not part of this term.
    assign o_load_use_stall = o_hz && !i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use bubble insertion.
// Update priority per edge: rst > flush_in > stall_in > hazard > load.
// Optional feature macro: ID_EX_PERF_CNT_EN adds the saturating bubble_cnt
// output counting hazard-induced bubbles.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   id_*                          - decoded instruction in ID
//   flush_in                      - redirect from EX, forces a bubble
//   stall_in                      - downstream hold, freezes all ex_*
//   ex_*                          - registered copy of id_*, plus ex_valid
//   load_use_stall                - freeze PC and IF/ID this cycle
//   bubble_cnt                    - load-use bubble count (macro only)
// ---------------------------------------------------------------------------
module id_ex_stage
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [3:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic            flush_in,
    input  logic            stall_in,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_use_rs1,
    output logic            ex_use_rs2,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            load_use_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     bubble_cnt
`endif
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_use_rs1;
    logic            r_use_rs2;
    logic [3:0]      r_alu_op;
    ctrl_t           r_ctrl;

    ctrl_t           w_id_ctrl;
    logic            w_hz;
    logic            w_clear;
    logic            w_load;

    assign w_id_ctrl = '{alu_src:    id_alu_src,
                         mem_read:   id_mem_read,
                         mem_write:  id_mem_write,
                         reg_write:  id_reg_write,
                         mem_to_reg: id_mem_to_reg,
                         branch:     id_branch,
                         jump:       id_jump};

    load_use_detect u_load_use_detect (
        .i_ex_valid       (r_valid),
        .i_ex_mem_read    (r_ctrl.mem_read),
        .i_ex_rd          (r_rd),
        .i_id_valid       (id_valid),
        .i_id_rs1         (id_rs1),
        .i_id_rs2         (id_rs2),
        .i_id_use_rs1     (id_use_rs1),
        .i_id_use_rs2     (id_use_rs2),
        .i_flush          (flush_in),
        .o_hz             (w_hz),
        .o_load_use_stall (load_use_stall)
    );

    // Reset, flush and an un-held hazard all produce the same all-zero bubble;
    // a hold only wins over the hazard, never over reset or flush.
    assign w_clear = rst || flush_in || (!stall_in && w_hz);
    assign w_load  = !stall_in && !w_hz;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_use_rs1  <= 1'b0;
            r_use_rs2  <= 1'b0;
            r_alu_op   <= '0;
            r_ctrl     <= '0;
        end else if (w_load) begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_imm      <= id_imm;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_use_rs1  <= id_use_rs1;
            r_use_rs2  <= id_use_rs2;
            r_alu_op   <= id_alu_op;
            r_ctrl     <= w_id_ctrl;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_imm        = r_imm;
    assign ex_rs1_data   = r_rs1_data;
    assign ex_rs2_data   = r_rs2_data;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_use_rs1    = r_use_rs1;
    assign ex_use_rs2    = r_use_rs2;
    assign ex_alu_op     = r_alu_op;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_branch     = r_ctrl.branch;
    assign ex_jump       = r_ctrl.jump;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;

    // Counts only hazard bubbles that actually land: flush and hold both
    // take priority over the hazard and must not be counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (!flush_in && !stall_in && w_hz && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed-vector bench for id_ex_stage. Each step drives one ID vector and
// pushes the hand-derived load_use_stall for that cycle and the ex_* state
// expected after the next rising edge; two monitors pop and compare.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_rs1;
        logic        use_rs2;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
    } vec_t;

    localparam int VW = $bits(vec_t);
    localparam int K_LOAD   = 0;
    localparam int K_BUBBLE = 1;
    localparam int K_HOLD   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_imm = '0, id_rs1_data = '0, id_rs2_data = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [3:0]  id_alu_op = '0;
    logic        id_alu_src = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic        id_reg_write = 1'b0, id_mem_to_reg = 1'b0, id_branch = 1'b0, id_jump = 1'b0;
    logic        flush_in = 1'b0, stall_in = 1'b0;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_use_rs1, ex_use_rs2;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
    logic        ex_mem_to_reg, ex_branch, ex_jump;
    logic        load_use_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .id_jump(id_jump),
        .flush_in(flush_in), .stall_in(stall_in),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_jump(ex_jump),
        .load_use_stall(load_use_stall)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [VW-1:0] exp_q[$];
    logic          stall_q[$];
    vec_t          exp_ex = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic is_load);
        vec_t v;
        v            = '0;
        v.valid      = 1'b1;
        v.pc         = pc;
        v.imm        = pc ^ 32'h0000_0055;
        v.rs1_data   = {pc[15:0], 16'hA5A5};
        v.rs2_data   = {16'h5A5A, pc[15:0]};
        v.rs1        = rs1;
        v.rs2        = rs2;
        v.rd         = rd;
        v.use_rs1    = u1;
        v.use_rs2    = u2;
        v.alu_op     = is_load ? 4'd0 : 4'd1;
        v.alu_src    = is_load;
        v.mem_read   = is_load;
        v.reg_write  = 1'b1;
        v.mem_to_reg = is_load;
        v.branch     = pc[2];
        return v;
    endfunction

    function automatic vec_t sample_ex();
        vec_t a;
        a.valid = ex_valid;         a.pc = ex_pc;             a.imm = ex_imm;
        a.rs1_data = ex_rs1_data;   a.rs2_data = ex_rs2_data;
        a.rs1 = ex_rs1;             a.rs2 = ex_rs2;           a.rd = ex_rd;
        a.use_rs1 = ex_use_rs1;     a.use_rs2 = ex_use_rs2;   a.alu_op = ex_alu_op;
        a.alu_src = ex_alu_src;     a.mem_read = ex_mem_read; a.mem_write = ex_mem_write;
        a.reg_write = ex_reg_write; a.mem_to_reg = ex_mem_to_reg;
        a.branch = ex_branch;       a.jump = ex_jump;
        return a;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input vec_t v, input logic fl, input logic st, input logic rs,
                        input logic chk_stall, input logic exp_stall, input int kind);
        @(posedge clk);
        #2;
        id_valid = v.valid;       id_pc = v.pc;               id_imm = v.imm;
        id_rs1_data = v.rs1_data; id_rs2_data = v.rs2_data;
        id_rs1 = v.rs1;           id_rs2 = v.rs2;             id_rd = v.rd;
        id_use_rs1 = v.use_rs1;   id_use_rs2 = v.use_rs2;     id_alu_op = v.alu_op;
        id_alu_src = v.alu_src;   id_mem_read = v.mem_read;   id_mem_write = v.mem_write;
        id_reg_write = v.reg_write; id_mem_to_reg = v.mem_to_reg;
        id_branch = v.branch;     id_jump = v.jump;
        flush_in = fl;            stall_in = st;              rst = rs;
        if (chk_stall) stall_q.push_back(exp_stall);
        if (kind == K_LOAD)        exp_ex = v;
        else if (kind == K_BUBBLE) exp_ex = '0;
        exp_q.push_back(exp_ex);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (stall_q.size() > 0) begin
            logic e;
            e = stall_q.pop_front();
            check("load_use_stall", {255'b0, load_use_stall}, {255'b0, e});
        end
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [VW-1:0] e;
            e = exp_q.pop_front();
            check("ex_bundle", {{(256-VW){1'b0}}, sample_ex()}, {{(256-VW){1'b0}}, e});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t nop, v;
        nop = '0;

        // Reset: outputs zero; stall not checked until the register is defined.
        step(mk(32'h40, 5'd5, 5'd2, 5'd0, 1, 0, 1), 0, 0, 1, 0, 0, K_BUBBLE);
        step(nop, 0, 0, 1, 1, 0, K_BUBBLE);

        // Load then use on rs1: one stall cycle, bubble, then the add loads.
        step(mk(32'h100, 5'd5, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h104, 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 1, K_BUBBLE);
        step(mk(32'h104, 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);

        // Load to x0 never stalls.
        step(mk(32'h108, 5'd0, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h10c, 5'd1, 5'd0, 5'd0, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);

        // Flush beats hazard.
        step(mk(32'h110, 5'd5, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h114, 5'd6, 5'd5, 5'd7, 1, 1, 0), 1, 0, 0, 1, 0, K_BUBBLE);
        step(mk(32'h118, 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);

        // Flush together with stall produces a bubble.
        step(mk(32'h11c, 5'd6, 5'd5, 5'd7, 1, 1, 0), 1, 1, 0, 1, 0, K_BUBBLE);

        // Stall hold for three cycles, then release.
        step(mk(32'h100, 5'd3, 5'd1, 5'd2, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);
        for (int i = 0; i < 3; i++)
            step(mk(32'h104, 5'd4, 5'd1, 5'd2, 1, 1, 0), 0, 1, 0, 1, 0, K_HOLD);
        step(mk(32'h104, 5'd4, 5'd1, 5'd2, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);

        // Hazard under downstream hold: stall flag still raised, state held.
        step(mk(32'h200, 5'd5, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h204, 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 1, 0, 1, 1, K_HOLD);
        step(mk(32'h204, 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 1, K_BUBBLE);
        step(mk(32'h204, 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);

        // Invalid ID slot with matching registers: no hazard, loads with valid 0.
        step(mk(32'h208, 5'd9, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
        v = mk(32'h20c, 5'd6, 5'd9, 5'd9, 1, 1, 0);
        v.valid = 1'b0;
        step(v, 0, 0, 0, 1, 0, K_LOAD);

        // rs2 match only counts when rs2 is used.
        step(mk(32'h210, 5'd9, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h214, 5'd6, 5'd1, 5'd9, 1, 0, 0), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h218, 5'd9, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h21c, 5'd6, 5'd1, 5'd9, 1, 1, 0), 0, 0, 0, 1, 1, K_BUBBLE);
        step(mk(32'h21c, 5'd6, 5'd1, 5'd9, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);

        // Reset during a hold discards state; next edge loads normally.
        step(mk(32'h300, 5'd3, 5'd1, 5'd2, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h304, 5'd3, 5'd1, 5'd2, 1, 1, 0), 0, 1, 1, 1, 0, K_BUBBLE);
        step(mk(32'h308, 5'd3, 5'd1, 5'd2, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);

`ifdef ID_EX_PERF_CNT_EN
        @(posedge clk);
        @(negedge clk);
        check("bubble_cnt_reset", {224'b0, bubble_cnt}, 256'd0);
        for (int i = 0; i < 4; i++) begin
            step(mk(32'h400 + 32'(i*16), 5'd5, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
            step(mk(32'h404 + 32'(i*16), 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 1, K_BUBBLE);
            step(mk(32'h404 + 32'(i*16), 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);
        end
        step(mk(32'h500, 5'd6, 5'd1, 5'd2, 1, 1, 0), 1, 0, 0, 1, 0, K_BUBBLE);
        step(mk(32'h504, 5'd5, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
        step(mk(32'h508, 5'd6, 5'd5, 5'd7, 1, 1, 0), 1, 0, 0, 1, 0, K_BUBBLE);
        step(mk(32'h50c, 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);
        @(posedge clk);
        @(negedge clk);
        check("bubble_cnt_four", {224'b0, bubble_cnt}, 256'd4);
        dut.r_bubble_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            step(mk(32'h600 + 32'(i*16), 5'd5, 5'd2, 5'd0, 1, 0, 1), 0, 0, 0, 1, 0, K_LOAD);
            step(mk(32'h604 + 32'(i*16), 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 1, K_BUBBLE);
            step(mk(32'h604 + 32'(i*16), 5'd6, 5'd5, 5'd7, 1, 1, 0), 0, 0, 0, 1, 0, K_LOAD);
        end
        @(posedge clk);
        @(negedge clk);
        check("bubble_cnt_sat", {224'b0, bubble_cnt}, {224'b0, 32'hFFFF_FFFF});
`endif

        // Let the monitors drain, then confirm nothing was left unchecked.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("exp_q_drained", 256'(exp_q.size()), 256'd0);
        check("stall_q_drained", 256'(stall_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock `clk`; reset is synchronous and active-high, port `rst`.
REQ-002 Ports, in this order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  32  decode PC
- id_imm  in  32  extended immediate from the immediate generator
- id_rs1_data, id_rs2_data  in  32 each  register-file read data
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction reads that source
- id_alu_op  in  4  ALU operation code
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch, id_jump  in  1 each  decoded control
- flush_in  in  1  redirect from EX (taken branch/jump)
- stall_in  in  1  downstream hold (memory busy)
- ex_*  out  same widths  registered copies of every id_* input above, plus ex_valid (1)
- load_use_stall  out  1  freeze PC and IF/ID this cycle
- bubble_cnt  out  32  load-use bubble count (only with ID_EX_PERF_CNT_EN)

Function
REQ-003 Hazard term, combinational: hz = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-004 load_use_stall SHALL equal hz & ~flush_in; it SHALL NOT depend on stall_in.
REQ-005 Register update priority, per rising edge: rst > flush_in > stall_in > hz > load.
- flush_in: insert bubble.
- stall_in (no flush): hold all ex_* unchanged.
- hz (no flush, no stall): insert bubble.
- otherwise: load all ex_* from id_*; ex_valid <= id_valid.
REQ-006 A bubble SHALL set ex_valid and all ex_ control bits to 0, and all ex_ data/index fields to 0.
REQ-007 Latency SHALL be exactly one cycle from id_* to ex_* when loading.
REQ-008 A load-use stall SHALL last exactly one cycle: after the bubble, ex_mem_read = 0, so hz deasserts and the held decode instruction loads on the next edge.
REQ-009 flush_in together with stall_in SHALL produce a bubble. flush_in together with hz SHALL produce a bubble with load_use_stall = 0.
REQ-010 When id_valid = 0, hz SHALL be 0 and the loaded ex_valid SHALL be 0.
REQ-011 rd = x0 SHALL never cause a hazard.

Reset
REQ-012 While rst = 1 at an edge, every ex_* output SHALL become 0, including ex_valid and ex_pc.
REQ-013 Reset asserted mid-stall SHALL discard held state. The first post-reset edge with rst = 0 SHALL load normally.
REQ-014 bubble_cnt SHALL reset to 0.

Configuration
REQ-015 Macro ID_EX_PERF_CNT_EN:
- Defined: bubble_cnt increments by 1 on every edge where a bubble is inserted due to hz (not flush), and saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Structure
REQ-016 Shared package rv32_pkg SHALL hold:
- ALU op encodings (4-bit)
- the control-bundle field list and widths
- REG_ZERO = 5'd0
- XLEN = 32
REQ-017 Hazard logic (REQ-003/004) SHALL be a sub-module load_use_detect; the pipeline register remains in id_ex_stage.

Verification
REQ-018 Load then use: EX holds lw x5 (ex_mem_read = 1, ex_rd = 5); ID holds add using rs1 = 5, use_rs1 = 1 -> load_use_stall = 1 for one cycle; next edge ex_valid = 0; following edge ex_rs1 = 5, ex_valid = 1.
REQ-019 Load to x0: ex_rd = 0, ex_mem_read = 1, id_rs1 = 0 -> load_use_stall = 0; the instruction loads directly.
REQ-020 Flush beats hazard: hazard conditions as in REQ-018 plus flush_in = 1 -> load_use_stall = 0; next edge ex_valid = 0 with all controls 0.
REQ-021 Stall hold: ex_pc = 32'h100, stall_in = 1 for 3 cycles while id_pc = 32'h104 -> ex_pc stays 32'h100; one edge after release ex_pc = 32'h104.
REQ-022 Reset mid-stall: stall_in = 1, ex_valid = 1, rst pulsed one cycle -> all ex_* = 0, bubble_cnt = 0.
REQ-023 Counter (macro defined): 4 separate load-use events and 2 flushes -> bubble_cnt = 4; preload near max -> value holds at 32'hFFFFFFFF.
